// File: rtl/alu_writeback_pkg.sv
// Shared types for the ALU writeback stage: op mnemonics, carry-updating op mask,
// write-queue entry and architectural flag bundle.
package alu_writeback_pkg;

    localparam int WB_DW  = 8;
    localparam int WB_RAW = 4;

    // kSRG sits above the 3-bit IN_OP range; its mask bit is kept for the wider decoder.
    typedef enum logic [3:0] {
        kADD = 4'd0,
        kSUB = 4'd1,
        kSLL = 4'd2,
        kSRL = 4'd3,
        kSRA = 4'd4,
        kSEQ = 4'd5,
        kSLG = 4'd6,
        kSCP = 4'd7,
        kSRG = 4'd8
    } op_mne;

    localparam logic [15:0] CARRY_OPS = (16'd1 << kADD) | (16'd1 << kSUB) | (16'd1 << kSLL) |
                                        (16'd1 << kSRL) | (16'd1 << kSRA) | (16'd1 << kSLG) |
                                        (16'd1 << kSRG) | (16'd1 << kSCP);

    typedef struct packed {
        logic [WB_RAW-1:0] dest;
        logic [WB_DW-1:0]  data;
    } wb_entry_t;

    typedef struct packed {
        logic c;
        logic z;
        logic a;
    } flags_t;

    function automatic logic is_carry_op(input logic [2:0] op);
        return CARRY_OPS[{1'b0, op}];
    endfunction

endpackage

// File: rtl/alu_writeback_queue.sv
// Small power-of-2 FIFO holding pending register-file writes; exposes head, youngest
// entry, occupancy count and full/empty. Head holds its last value while empty.
module wb_queue #(
    parameter int  DEPTH   = 2,
    parameter type entry_t = logic [11:0]
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  entry_t                  push_data,
    input  logic                    pop,
    output entry_t                  head,
    output entry_t                  youngest,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t        mem [DEPTH];
    entry_t        last_head;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            last_head <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= push_data;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) begin
                last_head <= mem[rptr];
                rptr      <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head     = empty ? last_head : mem[rptr];
    assign youngest = empty ? entry_t'('0) : mem[AW'(wptr - 1'b1)];

endmodule

// File: rtl/alu_writeback.sv
// Execute/writeback stage after the ALU: owns carry/zero/sticky-A flags and queues RF writes.
// Optional macro ALU_WB_FWD_EN exposes the youngest queued write on the FWD_* bypass ports.
module alu_writeback
    import alu_writeback_pkg::*;
#(
    parameter int DW    = WB_DW,
    parameter int RAW   = WB_RAW,
    parameter int DEPTH = 2
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic           IN_VALID,
    output logic           IN_READY,
    input  logic [2:0]     IN_OP,
    input  logic           IN_WEN,
    input  logic [RAW-1:0] IN_DEST,
    input  logic [DW-1:0]  ALU_OUT,
    input  logic           ALU_CO,
    input  logic           ALU_ZERO,
    input  logic           ALU_FLAGA,
    input  logic           FLAG_CLR,
    output logic           CI_OUT,
    output logic           Z_FLAG,
    output logic           A_FLAG,
    output logic           RF_WE,
    output logic [RAW-1:0] RF_WADDR,
    output logic [DW-1:0]  RF_WDATA,
    input  logic           RF_READY,
    output logic           FWD_VALID,
    output logic [RAW-1:0] FWD_ADDR,
    output logic [DW-1:0]  FWD_DATA
);
    localparam int CW = $clog2(DEPTH) + 1;

    flags_t        flags;
    flags_t        flags_next;
    wb_entry_t     in_entry;
    wb_entry_t     head;
    wb_entry_t     youngest;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          accept;
    logic          push;
    logic          pop;

    assign IN_READY = ~full;
    assign accept   = IN_VALID & IN_READY;
    assign push     = accept & IN_WEN;
    assign RF_WE    = ~empty;
    assign pop      = RF_WE & RF_READY;
    assign in_entry = '{dest: IN_DEST, data: ALU_OUT};

    wb_queue #(
        .DEPTH   (DEPTH),
        .entry_t (wb_entry_t)
    ) u_queue (
        .clk       (CLK),
        .reset     (RESET),
        .push      (push),
        .push_data (in_entry),
        .pop       (pop),
        .head      (head),
        .youngest  (youngest),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // A set from an accepted op overrides a same-cycle clear.
    always_comb begin
        flags_next = flags;
        if (accept) begin
            if (is_carry_op(IN_OP)) flags_next.c = ALU_CO;
            flags_next.z = ALU_ZERO;
        end
        flags_next.a = (flags.a & ~FLAG_CLR) | (accept & ALU_FLAGA);
    end

    always_ff @(posedge CLK) begin
        if (RESET) flags <= '0;
        else       flags <= flags_next;
    end

    assign CI_OUT   = flags.c;
    assign Z_FLAG   = flags.z;
    assign A_FLAG   = flags.a;
    assign RF_WADDR = head.dest;
    assign RF_WDATA = head.data;

`ifdef ALU_WB_FWD_EN
    assign FWD_VALID = RF_WE;
    assign FWD_ADDR  = youngest.dest;
    assign FWD_DATA  = youngest.data;
`else
    logic unused_youngest;
    assign unused_youngest = ^youngest;
    assign FWD_VALID = 1'b0;
    assign FWD_ADDR  = '0;
    assign FWD_DATA  = '0;
`endif

    count_bound : assert property (@(posedge CLK) disable iff (RESET) count <= CW'(DEPTH));

endmodule

// File: tb/tb_alu_writeback.sv
// Directed plus randomized bench for alu_writeback against a queue-based reference model.
`timescale 1ns/1ps
module tb_alu_writeback;
    import alu_writeback_pkg::*;

    localparam int DW    = 8;
    localparam int RAW   = 4;
    localparam int DEPTH = 2;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [2:0]     in_op = '0;
    logic           in_wen = 1'b0;
    logic [RAW-1:0] in_dest = '0;
    logic [DW-1:0]  alu_out = '0;
    logic           alu_co = 1'b0;
    logic           alu_zero = 1'b0;
    logic           alu_flaga = 1'b0;
    logic           flag_clr = 1'b0;
    logic           ci_out, z_flag, a_flag;
    logic           rf_we;
    logic [RAW-1:0] rf_waddr;
    logic [DW-1:0]  rf_wdata;
    logic           rf_ready = 1'b0;
    logic           fwd_valid;
    logic [RAW-1:0] fwd_addr;
    logic [DW-1:0]  fwd_data;

    int n_assert = 0;
    int n_fail   = 0;

    wb_entry_t mq[$];
    wb_entry_t m_last;
    logic      m_c, m_z, m_a;
    logic      last_acc;

    always #5 clk = ~clk;

    alu_writeback #(.DW(DW), .RAW(RAW), .DEPTH(DEPTH)) dut (
        .CLK       (clk),
        .RESET     (reset),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .IN_OP     (in_op),
        .IN_WEN    (in_wen),
        .IN_DEST   (in_dest),
        .ALU_OUT   (alu_out),
        .ALU_CO    (alu_co),
        .ALU_ZERO  (alu_zero),
        .ALU_FLAGA (alu_flaga),
        .FLAG_CLR  (flag_clr),
        .CI_OUT    (ci_out),
        .Z_FLAG    (z_flag),
        .A_FLAG    (a_flag),
        .RF_WE     (rf_we),
        .RF_WADDR  (rf_waddr),
        .RF_WDATA  (rf_wdata),
        .RF_READY  (rf_ready),
        .FWD_VALID (fwd_valid),
        .FWD_ADDR  (fwd_addr),
        .FWD_DATA  (fwd_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit carries(input logic [2:0] op);
        op_mne m;
        m = op_mne'({1'b0, op});
        return m inside {kADD, kSUB, kSLL, kSRL, kSRA, kSLG, kSRG, kSCP};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_last = '0;
        m_c = 1'b0;
        m_z = 1'b0;
        m_a = 1'b0;
    endtask

    task automatic check_model();
        int sz;
        sz = mq.size();
        chk("in_ready", 32'(in_ready), (sz < DEPTH) ? 1 : 0);
        chk("rf_we", 32'(rf_we), (sz != 0) ? 1 : 0);
        chk("rf_waddr", 32'(rf_waddr), 32'((sz != 0) ? mq[0].dest : m_last.dest));
        chk("rf_wdata", 32'(rf_wdata), 32'((sz != 0) ? mq[0].data : m_last.data));
        chk("ci_out", 32'(ci_out), 32'(m_c));
        chk("z_flag", 32'(z_flag), 32'(m_z));
        chk("a_flag", 32'(a_flag), 32'(m_a));
`ifdef ALU_WB_FWD_EN
        chk("fwd_valid", 32'(fwd_valid), (sz != 0) ? 1 : 0);
        if (sz != 0) begin
            chk("fwd_addr", 32'(fwd_addr), 32'(mq[sz-1].dest));
            chk("fwd_data", 32'(fwd_data), 32'(mq[sz-1].data));
        end
`else
        chk("fwd_valid", 32'(fwd_valid), 0);
        chk("fwd_addr", 32'(fwd_addr), 0);
        chk("fwd_data", 32'(fwd_data), 0);
`endif
    endtask

    task automatic advance_model();
        logic acc;
        acc = in_valid && (mq.size() < DEPTH) && !reset;
        last_acc = acc;
        if (reset) begin
            model_reset();
            return;
        end
        if (mq.size() != 0 && rf_ready) m_last = mq.pop_front();
        if (acc && in_wen) mq.push_back(wb_entry_t'{in_dest, alu_out});
        if (acc) begin
            if (carries(in_op)) m_c = alu_co;
            m_z = alu_zero;
        end
        m_a = (m_a && !flag_clr) || (acc && alu_flaga);
    endtask

    task automatic cycle();
        @(negedge clk);
        check_model();
        advance_model();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [RAW-1:0] dest, input logic [DW-1:0] data,
                        input logic co, input logic zero, input logic fa, input logic wen, input logic clr);
        bit done;
        in_valid = 1'b1; in_op = op; in_dest = dest; alu_out = data;
        alu_co = co; alu_zero = zero; alu_flaga = fa; in_wen = wen; flag_clr = clr;
        done = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (last_acc) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            n_assert++;
            n_fail++;
            $error("FAIL send_timeout: observed not accepted expected accepted");
        end
        in_valid = 1'b0;
        flag_clr = 1'b0;
    endtask

    task automatic drain();
        rf_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (mq.size() == 0) break;
            cycle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        last_acc = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_rf_we", 32'(rf_we), 0);
        chk("rst_rf_waddr", 32'(rf_waddr), 0);
        chk("rst_rf_wdata", 32'(rf_wdata), 0);
        chk("rst_flags", 32'({ci_out, z_flag, a_flag}), 0);
        chk("rst_fwd_valid", 32'(fwd_valid), 0);

        // Test 1: carry op sets C and Z, entry reaches head the next cycle
        rf_ready = 1'b0;
        send(3'(kADD), 4'd3, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("t1_ci", 32'(ci_out), 1);
        chk("t1_z", 32'(z_flag), 1);
        chk("t1_rf_we", 32'(rf_we), 1);
        chk("t1_waddr", 32'(rf_waddr), 3);
        chk("t1_wdata", 32'(rf_wdata), 0);

        // Test 2: non-carry op leaves C alone
        send(3'(kSEQ), 4'd1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_ci", 32'(ci_out), 1);
        chk("t2_z", 32'(z_flag), 0);

        // Test 3: backpressure, full queue and in-order drain
        drain();
        rf_ready = 1'b0;
        send(3'(kSEQ), 4'd1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send(3'(kSEQ), 4'd2, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3_full_ready", 32'(in_ready), 0);
        chk("t3_head_a", 32'(rf_waddr), 1);
        in_valid = 1'b1; in_op = 3'(kSEQ); in_dest = 4'd4; alu_out = 8'h44; in_wen = 1'b1;
        cycle();
        cycle();
        chk("t3_held_ready", 32'(in_ready), 0);
        chk("t3_held_head", 32'(rf_wdata), 32'h11);
        rf_ready = 1'b1;
        cycle();
        chk("t3_after_pop_ready", 32'(in_ready), 1);
        chk("t3_head_b", 32'(rf_waddr), 2);
        cycle();
        chk("t3_third_accepted", 32'(last_acc), 1);
        chk("t3_head_c_addr", 32'(rf_waddr), 4);
        chk("t3_head_c_data", 32'(rf_wdata), 32'h44);
        in_valid = 1'b0;
        drain();

        // Test 4: sticky A, set beats clear, then clear alone
        send(3'(kSCP), 4'd0, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("t4_a_set", 32'(a_flag), 1);
        chk("t4_ci", 32'(ci_out), 0);
        flag_clr = 1'b1;
        cycle();
        flag_clr = 1'b0;
        chk("t4_a_clr", 32'(a_flag), 0);

        // Test 5: reset discards queued writes and flags
        rf_ready = 1'b0;
        send(3'(kADD), 4'd6, 8'h10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        send(3'(kSUB), 4'd7, 8'h20, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("t5_full", 32'(in_ready), 0);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("t5_rf_we", 32'(rf_we), 0);
        chk("t5_in_ready", 32'(in_ready), 1);
        chk("t5_flags", 32'({ci_out, z_flag, a_flag}), 0);

        // Test 6: bypass shows the youngest queued write
        send(3'(kSLL), 4'd5, 8'hA7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef ALU_WB_FWD_EN
        chk("t6_fwd_valid", 32'(fwd_valid), 1);
        chk("t6_fwd_addr", 32'(fwd_addr), 5);
        chk("t6_fwd_data", 32'(fwd_data), 32'hA7);
`else
        chk("t6_fwd_valid", 32'(fwd_valid), 0);
`endif
        drain();

        // Randomized traffic; an unaccepted op is held until it is taken
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || last_acc) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_op     = 3'($urandom);
                in_wen    = ($urandom_range(0, 3) != 0);
                in_dest   = RAW'($urandom);
                alu_out   = DW'($urandom);
                alu_co    = 1'($urandom);
                alu_zero  = 1'($urandom);
                alu_flaga = ($urandom_range(0, 3) == 0);
            end
            rf_ready = ($urandom_range(0, 2) != 0);
            flag_clr = ($urandom_range(0, 7) == 0);
            reset    = ($urandom_range(0, 63) == 0);
            cycle();
        end
        reset = 1'b0;
        in_valid = 1'b0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
